// File: rtl/rv32_pkg.sv
// Shared RV32I encodings, ALU op codes and the issue-packet payload for the EX issue stage.
package rv32_pkg;

  localparam int unsigned XLEN_W = 32;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_XOR  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;

  // Where an operand came from; only register-sourced operands are bypassable.
  localparam logic [1:0] SRC_FIXED = 2'b00;
  localparam logic [1:0] SRC_RS1   = 2'b01;
  localparam logic [1:0] SRC_RS2   = 2'b10;

  typedef struct packed {
    logic [XLEN_W-1:0] a;
    logic [XLEN_W-1:0] b;
    logic [3:0]        alu_op;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [1:0]        a_src;
    logic [1:0]        b_src;
    logic              illegal;
  } issue_pkt_t;

  // Replace register-sourced operands of a held packet with a matching write-back value.
  function automatic issue_pkt_t bypass_pkt(issue_pkt_t p, logic wb_valid,
                                            logic [4:0] wb_rd, logic [XLEN_W-1:0] wb_data);
    issue_pkt_t r;
    logic       hit1;
    logic       hit2;
    r    = p;
    hit1 = wb_valid && (wb_rd != 5'd0) && (wb_rd == p.rs1);
    hit2 = wb_valid && (wb_rd != 5'd0) && (wb_rd == p.rs2);
    if (((p.a_src == SRC_RS1) && hit1) || ((p.a_src == SRC_RS2) && hit2)) r.a = wb_data;
    if (((p.b_src == SRC_RS1) && hit1) || ((p.b_src == SRC_RS2) && hit2)) r.b = wb_data;
    return r;
  endfunction

endpackage

// File: rtl/ex_issue_decode.sv
// Combinational RV32I instruction -> ALU issue packet decoder (operands already bypassed).
module ex_issue_decode
  import rv32_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  output issue_pkt_t  pkt
);

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i;
  logic [31:0] imm_u;
  logic        is_imm;
  logic        is_shift;
  logic        legal;
  issue_pkt_t  raw;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_u  = {instr[31:12], 12'b0};
  assign is_imm = (opcode == OPC_OP_IMM);

  // Field decode; illegal packets are zeroed afterwards.
  always_comb begin
    raw      = '0;
    legal    = 1'b0;
    is_shift = 1'b0;
    raw.rd   = instr[11:7];
    case (opcode)
      OPC_OP, OPC_OP_IMM: begin
        raw.rs1   = instr[19:15];
        raw.a     = rs1_val;
        raw.a_src = SRC_RS1;
        if (is_imm) begin
          raw.b     = imm_i;
          raw.b_src = SRC_FIXED;
        end else begin
          raw.rs2   = instr[24:20];
          raw.b     = rs2_val;
          raw.b_src = SRC_RS2;
        end
        case (f3)
          F3_ADD: begin
            legal      = is_imm || (f7 == F7_BASE) || (f7 == F7_ALT);
            raw.alu_op = (!is_imm && (f7 == F7_ALT)) ? ALU_SUB : ALU_ADD;
          end
          F3_SLL: begin
            legal      = (f7 == F7_BASE);
            raw.alu_op = ALU_SLL;
            is_shift   = 1'b1;
          end
          F3_SLT:  legal = 1'b0;
          F3_SLTU: begin
            legal      = is_imm || (f7 == F7_BASE);
            raw.alu_op = ALU_SLTU;
          end
          F3_XOR: begin
            legal      = is_imm || (f7 == F7_BASE);
            raw.alu_op = ALU_XOR;
          end
          F3_SR: begin
            legal      = (f7 == F7_BASE) || (f7 == F7_ALT);
            raw.alu_op = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            is_shift   = 1'b1;
          end
          F3_OR: begin
            legal      = is_imm || (f7 == F7_BASE);
            raw.alu_op = ALU_OR;
          end
          default: begin
            legal      = is_imm || (f7 == F7_BASE);
            raw.alu_op = ALU_AND;
          end
        endcase
        // The ALU shifts b by a[4:0], so the shifted value goes to b.
        if (is_shift) begin
          raw.b     = rs1_val;
          raw.b_src = SRC_RS1;
          if (is_imm) begin
            raw.a     = {27'b0, instr[24:20]};
            raw.a_src = SRC_FIXED;
          end else begin
            raw.a     = rs2_val;
            raw.a_src = SRC_RS2;
          end
        end
      end
      OPC_LUI: begin
        legal      = 1'b1;
        raw.alu_op = ALU_ADD;
        raw.a      = '0;
        raw.b      = imm_u;
      end
      OPC_AUIPC: begin
        legal      = 1'b1;
        raw.alu_op = ALU_ADD;
        raw.a      = pc;
        raw.b      = imm_u;
      end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    pkt = raw;
    if (!legal) begin
      pkt         = '0;
      pkt.a_src   = SRC_FIXED;
      pkt.b_src   = SRC_FIXED;
      pkt.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/ex_issue.sv
// EX issue stage: decode, write-back bypass and a two-entry output/skid buffer.
module ex_issue
  import rv32_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_val,
  input  logic [XLEN-1:0] in_rs2_val,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [3:0]      out_alu_op,
  output logic [4:0]      out_rd,
  output logic            out_illegal
);

  // Bit 0 = output register valid, bit 1 = skid valid.
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b11;

  logic [1:0]      state;
  logic [1:0]      state_nxt;
  issue_pkt_t      out_q;
  issue_pkt_t      out_d;
  issue_pkt_t      skid_q;
  issue_pkt_t      skid_d;
  issue_pkt_t      dec_pkt;
  issue_pkt_t      out_held;
  issue_pkt_t      skid_held;
  logic [XLEN-1:0] rs1_byp;
  logic [XLEN-1:0] rs2_byp;
  logic            wb_hit_ok;
  logic            in_fire;
  logic            out_fire;

  // Capture-time bypass: a write-back in the same edge overrides the register file.
  assign wb_hit_ok = wb_valid && (wb_rd != 5'd0);
  assign rs1_byp   = (wb_hit_ok && (wb_rd == in_instr[19:15])) ? wb_data : in_rs1_val;
  assign rs2_byp   = (wb_hit_ok && (wb_rd == in_instr[24:20])) ? wb_data : in_rs2_val;

  ex_issue_decode u_decode (
    .instr   (in_instr),
    .pc      (in_pc),
    .rs1_val (rs1_byp),
    .rs2_val (rs2_byp),
    .pkt     (dec_pkt)
  );

  assign out_held  = bypass_pkt(out_q, wb_valid, wb_rd, wb_data);
  assign skid_held = bypass_pkt(skid_q, wb_valid, wb_rd, wb_data);

  assign in_ready  = ~state[1];
  assign out_valid = state[0];
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // Next state and buffer contents; held entries always take the bypassed copy.
  always_comb begin
    state_nxt = state;
    out_d     = out_held;
    skid_d    = skid_held;
    case (state)
      ST_EMPTY: begin
        if (in_fire) begin
          out_d     = dec_pkt;
          state_nxt = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_fire && out_fire) begin
          out_d = dec_pkt;
        end else if (in_fire) begin
          skid_d    = dec_pkt;
          state_nxt = ST_FULL;
        end else if (out_fire) begin
          state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          out_d     = skid_held;
          state_nxt = ST_ONE;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_EMPTY;
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      state  <= state_nxt;
      out_q  <= out_d;
      skid_q <= skid_d;
    end
  end

  assign out_a       = out_q.a;
  assign out_b       = out_q.b;
  assign out_alu_op  = out_q.alu_op;
  assign out_rd      = out_q.rd;
  assign out_illegal = out_q.illegal;

endmodule
